scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_OBS, default 48; number of sticker observations per scan (24 corner, 24 edge).
REQ-002 SHALL have parameter TIMEOUT, default 24'd10_000_000; maximum cycles waited in any WAIT state.
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; begins a scan when sampled high in IDLE.
REQ-006 SHALL have port abort  input  1  level; cancels any scan in progress.
REQ-007 SHALL have port moves_done  input  1  one-cycle pulse from move executor: current batch finished, including empty batches.
REQ-008 SHALL have port sample_valid  input  1  one-cycle pulse from colour sensor: observation captured.
REQ-009 SHALL have port send_setup_moves  output  1  one-cycle pulse requesting the move batch indexed by counter.
REQ-010 SHALL have port counter  output  6  batch/observation index fed to the move-batch generator and sticker store.
REQ-011 SHALL have port sample_req  output  1  one-cycle pulse requesting one colour observation.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-013 SHALL have port scan_done  output  1  held high in DONE.
REQ-014 SHALL have port error  output  1  held high in ERROR.

Function
REQ-015 SHALL implement states IDLE, REQ_MOVES, WAIT_MOVES, REQ_SAMPLE, WAIT_SAMPLE, ADVANCE, DONE, ERROR.
REQ-016 SHALL move IDLE->REQ_MOVES on start=1 and clear counter to 0 on that transition.
REQ-017 SHALL assert send_setup_moves for exactly the one cycle spent in REQ_MOVES, then enter WAIT_MOVES unconditionally.
REQ-018 SHALL, in WAIT_MOVES on moves_done=1, enter REQ_SAMPLE if counter<NUM_OBS, else enter DONE.
REQ-019 SHALL assert sample_req for exactly the one cycle spent in REQ_SAMPLE, then enter WAIT_SAMPLE.
REQ-020 SHALL, in WAIT_SAMPLE on sample_valid=1, enter ADVANCE.
REQ-021 SHALL, in ADVANCE, increment counter by 1 and enter REQ_MOVES; counter reaches NUM_OBS only for the final restore batch and never wraps.
REQ-022 SHALL hold counter stable from REQ_MOVES through WAIT_SAMPLE of the same step.
REQ-023 SHALL ignore moves_done outside WAIT_MOVES and sample_valid outside WAIT_SAMPLE.
REQ-024 SHALL ignore start in every state other than IDLE, DONE and ERROR.
REQ-025 SHALL, in DONE or ERROR, hold the state until start=1, then behave as in REQ-016.
REQ-026 SHALL keep a wait timer that clears on entry to WAIT_MOVES or WAIT_SAMPLE and increments each cycle in those states.
REQ-027 SHALL enter ERROR when the wait timer equals TIMEOUT-1 and the expected pulse is absent in the same cycle; if the pulse is present, the pulse wins.
REQ-028 SHALL, on abort=1 in any state except IDLE, enter IDLE next cycle with counter cleared and no pulse outputs; abort takes priority over start and over every other transition.
REQ-029 SHALL produce a total sequence of NUM_OBS+1 send_setup_moves pulses and NUM_OBS sample_req pulses per successful scan.

Reset
REQ-030 SHALL, while reset=1, force state IDLE, counter=0, wait timer=0, and send_setup_moves, sample_req, busy, scan_done, error all 0, independent of clock.
REQ-031 SHALL, on reset asserted mid-scan, discard all progress; the first scan after release restarts at counter=0.

Verification
REQ-032 Full scan: start pulse, executor returns moves_done 5 cycles after each send_setup_moves, sensor returns sample_valid 3 cycles after each sample_req -> 49 send pulses (counter 0..48), 48 sample_req pulses (counter 0..47), scan_done=1, busy=0.
REQ-033 Timeout: TIMEOUT=100, withhold moves_done at counter=7 -> error=1 exactly 100 cycles after WAIT_MOVES entry, counter stays 7, busy=0.
REQ-034 Abort: abort=1 while in WAIT_SAMPLE at counter=20 -> IDLE next cycle, counter=0, no further pulses; subsequent start restarts at counter=0.
REQ-035 Spurious inputs: moves_done during WAIT_SAMPLE, sample_valid during WAIT_MOVES, start mid-scan -> no state or counter change.
REQ-036 Async reset: reset asserted between clock edges at counter=30 -> all outputs 0 immediately; after release, start -> send_setup_moves with counter=0.
REQ-037 Boundary: moves_done in the same cycle the timer reaches TIMEOUT-1 -> proceeds to REQ_SAMPLE, error stays 0.

Source files
------------

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - sticker scan sequencer: alternates setup-move batches with colour samples
// Drives NUM_OBS observation steps plus a final restore batch, with a per-wait watchdog.
module scan_sequencer #(
    parameter int          NUM_OBS = 48,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       moves_done,
    input  logic       sample_valid,
    output logic       send_setup_moves,
    output logic [5:0] counter,
    output logic       sample_req,
    output logic       busy,
    output logic       scan_done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_MOVES,
        S_WAIT_MOVES,
        S_REQ_SAMPLE,
        S_WAIT_SAMPLE,
        S_ADVANCE,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [5:0]  LAST_IDX   = 6'(NUM_OBS);
    localparam logic [23:0] TIMER_LAST = TIMEOUT - 24'd1;

    state_e      state_q, state_d;
    logic [5:0]  counter_q, counter_d;
    logic [23:0] timer_q, timer_d;
    logic        send_q, sample_q, busy_q, done_q, error_q;
    logic        timed_out;
    logic        in_wait_d;

    assign timed_out = (timer_q == TIMER_LAST);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_REQ_MOVES;
                    counter_d = 6'd0;
                end
            end
            S_REQ_MOVES:  state_d = S_WAIT_MOVES;
            S_WAIT_MOVES: begin
                // The pulse wins over a timeout landing in the same cycle.
                if (moves_done)
                    state_d = (counter_q < LAST_IDX) ? S_REQ_SAMPLE : S_DONE;
                else if (timed_out)
                    state_d = S_ERROR;
            end
            S_REQ_SAMPLE: state_d = S_WAIT_SAMPLE;
            S_WAIT_SAMPLE: begin
                if (sample_valid)
                    state_d = S_ADVANCE;
                else if (timed_out)
                    state_d = S_ERROR;
            end
            S_ADVANCE: begin
                counter_d = counter_q + 6'd1;
                state_d   = S_REQ_MOVES;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            counter_d = 6'd0;
        end
    end

    assign in_wait_d = (state_d == S_WAIT_MOVES) || (state_d == S_WAIT_SAMPLE);

    // Timer restarts on every state change, so each wait gets a fresh budget.
    always_comb begin
        timer_d = 24'd0;
        if (in_wait_d && (state_d == state_q))
            timer_d = timer_q + 24'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            counter_q <= 6'd0;
            timer_q   <= 24'd0;
            send_q    <= 1'b0;
            sample_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            timer_q   <= timer_d;
            send_q    <= (state_d == S_REQ_MOVES);
            sample_q  <= (state_d == S_REQ_SAMPLE);
            busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
            done_q    <= (state_d == S_DONE);
            error_q   <= (state_d == S_ERROR);
        end
    end

    assign send_setup_moves = send_q;
    assign sample_req       = sample_q;
    assign counter          = counter_q;
    assign busy             = busy_q;
    assign scan_done        = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed vector and scenario bench for scan_sequencer
module tb_scan_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       moves_done = 1'b0;
    logic       sample_valid = 1'b0;
    logic       send_setup_moves;
    logic [5:0] counter;
    logic       sample_req;
    logic       busy;
    logic       scan_done;
    logic       error;

    scan_sequencer #(.NUM_OBS(48), .TIMEOUT(24'd100)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .moves_done       (moves_done),
        .sample_valid     (sample_valid),
        .send_setup_moves (send_setup_moves),
        .counter          (counter),
        .sample_req       (sample_req),
        .busy             (busy),
        .scan_done        (scan_done),
        .error            (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] in;   // {start, abort, moves_done, sample_valid}
        logic [4:0] o;    // {send, sample_req, busy, scan_done, error}
        logic [5:0] cnt;
    } vec_t;

    vec_t vecs[14];
    int   passed = 0;
    int   total = 0;
    int   md_cnt = -1;
    int   sv_cnt = -1;
    int   hold_idx = -1;
    int   sends = 0;
    int   samples = 0;
    int   bad_idx = 0;

    function automatic vec_t mk(input logic [3:0] in, input logic [4:0] o, input logic [5:0] c);
        vec_t v;
        v.in = in;
        v.o = o;
        v.cnt = c;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {send_setup_moves, sample_req, busy, scan_done, error, counter};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        start = 1'b0;
        abort = 1'b0;
        moves_done = 1'b0;
        sample_valid = 1'b0;
        md_cnt = -1;
        sv_cnt = -1;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sends = 0;
        samples = 0;
        bad_idx = 0;
    endtask

    // Executor answers 5 cycles after send, sensor 3 cycles after sample_req.
    task automatic step_resp();
        moves_done = (md_cnt == 0);
        sample_valid = (sv_cnt == 0);
        if (md_cnt >= 0) md_cnt--;
        if (sv_cnt >= 0) sv_cnt--;
        tick();
        if (send_setup_moves) begin
            if (int'(counter) != sends) bad_idx++;
            sends++;
            if (int'(counter) != hold_idx) md_cnt = 4;
        end
        if (sample_req) begin
            if (int'(counter) != samples) bad_idx++;
            samples++;
            sv_cnt = 2;
        end
    endtask

    task automatic run_until(input bit want_sample, input int idx, output bit hit);
        hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            step_resp();
            if (want_sample) hit = sample_req && (int'(counter) == idx);
            else hit = send_setup_moves && (int'(counter) == idx);
        end
    endtask

    initial begin
        bit hit;
        int first_err;
        int stray;

        vecs[0]  = mk(4'b1000, 5'b10100, 6'd0);
        vecs[1]  = mk(4'b0000, 5'b00100, 6'd0);
        vecs[2]  = mk(4'b0001, 5'b00100, 6'd0);
        vecs[3]  = mk(4'b1000, 5'b00100, 6'd0);
        vecs[4]  = mk(4'b0010, 5'b01100, 6'd0);
        vecs[5]  = mk(4'b0010, 5'b00100, 6'd0);
        vecs[6]  = mk(4'b0010, 5'b00100, 6'd0);
        vecs[7]  = mk(4'b0001, 5'b00100, 6'd0);
        vecs[8]  = mk(4'b0000, 5'b10100, 6'd1);
        vecs[9]  = mk(4'b0000, 5'b00100, 6'd1);
        vecs[10] = mk(4'b0010, 5'b01100, 6'd1);
        vecs[11] = mk(4'b0100, 5'b00000, 6'd0);
        vecs[12] = mk(4'b1000, 5'b10100, 6'd0);
        vecs[13] = mk(4'b0100, 5'b00000, 6'd0);

        #12;
        chk("reset_state", 32'(outs()), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            {start, abort, moves_done, sample_valid} = vecs[i].in;
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'({vecs[i].o, vecs[i].cnt}));
        end

        // Full scan
        do_reset();
        hold_idx = -1;
        start = 1'b1;
        step_resp();
        start = 1'b0;
        for (int c = 0; c < 3000 && !scan_done; c++) step_resp();
        chk("full_sends", 32'(sends), 32'd49);
        chk("full_samples", 32'(samples), 32'd48);
        chk("full_index_errs", 32'(bad_idx), 32'd0);
        chk("full_done", 32'({scan_done, busy, error}), 32'b100);
        chk("full_counter", 32'(counter), 32'd48);

        // Timeout with moves_done withheld at counter 7
        do_reset();
        hold_idx = 7;
        start = 1'b1;
        step_resp();
        start = 1'b0;
        run_until(1'b0, 7, hit);
        chk("to_reach7", 32'(hit), 32'd1);
        first_err = -1;
        for (int i = 1; i <= 150 && first_err < 0; i++) begin
            step_resp();
            if (error) first_err = i;
        end
        chk("to_latency", 32'(first_err), 32'd101);
        chk("to_state", 32'({error, busy, counter}), 32'({1'b1, 1'b0, 6'd7}));

        // moves_done on the last timer cycle still wins
        do_reset();
        hold_idx = 0;
        start = 1'b1;
        step_resp();
        start = 1'b0;
        for (int i = 0; i < 100; i++) step_resp();
        chk("bnd_no_err_yet", 32'({error, busy}), 32'b01);
        moves_done = 1'b1;
        tick();
        moves_done = 1'b0;
        chk("bnd_proceeds", 32'({sample_req, error, busy}), 32'b101);
        hold_idx = -1;

        // Abort in WAIT_SAMPLE at counter 20
        do_reset();
        start = 1'b1;
        step_resp();
        start = 1'b0;
        run_until(1'b1, 20, hit);
        chk("ab_reach20", 32'(hit), 32'd1);
        clr_in();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle", 32'(outs()), 32'd0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            moves_done = (i == 3);
            sample_valid = (i == 6);
            tick();
            if (send_setup_moves || sample_req || busy) stray++;
        end
        moves_done = 1'b0;
        sample_valid = 1'b0;
        chk("ab_no_pulses", 32'(stray), 32'd0);
        sends = 0;
        samples = 0;
        bad_idx = 0;
        start = 1'b1;
        step_resp();
        start = 1'b0;
        chk("ab_restart", 32'({send_setup_moves, counter}), 32'({1'b1, 6'd0}));

        // Asynchronous reset mid-scan at counter 30
        run_until(1'b0, 30, hit);
        chk("rst_reach30", 32'(hit), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async", 32'(outs()), 32'd0);
        @(posedge clock);
        #1;
        clr_in();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_restart", 32'({send_setup_moves, counter}), 32'({1'b1, 6'd0}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
